// File: rtl/drive_pkg.sv
// drive_pkg: shared drive command and mode types plus IR remote codes
package drive_pkg;
    typedef enum logic [2:0] {
        STOP       = 3'd0,
        FAST_LEFT  = 3'd1,
        LEFT       = 3'd2,
        STRAIGHT   = 3'd3,
        RIGHT      = 3'd4,
        FAST_RIGHT = 3'd5
    } drive_e;
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TRACK = 2'd1,
        STUN  = 2'd2
    } mode_e;
    localparam logic [31:0] IR_PLAY   = 32'he9166b86;
    localparam logic [31:0] IR_POWER  = 32'hed126b86;
    localparam logic [31:0] IR_MUTE   = 32'hf30c6b86;
    localparam logic [31:0] IR_RETURN = 32'he8176b86;
    localparam logic [31:0] IR_UP     = 32'he51a6b86;
    localparam logic [31:0] IR_DOWN   = 32'he11e6b86;
endpackage

// File: rtl/drive_controller_if.sv
// drive_controller_if: valid/ready command handshake from controller to motor block
interface drive_controller_if;
    import drive_pkg::*;
    drive_e drive_command;
    logic   cmd_valid;
    logic   cmd_ready;
    modport master(output drive_command, cmd_valid, input cmd_ready);
    modport slave(input drive_command, cmd_valid, output cmd_ready);
endinterface

// File: rtl/drive_controller_steer_debounce.sv
// steer_debounce: classifies the target bin into a steering zone and debounces it
module steer_debounce
    import drive_pkg::*;
#(
    parameter int FOV      = 25,
    parameter int DIR_W    = $clog2(FOV) + 1,
    parameter int BAND_IN  = 4,
    parameter int BAND_OUT = 9,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [DIR_W-1:0] dir,
    output drive_e           zone
);
    localparam int C  = FOV / 2;
    localparam int CW = $clog2(DEBOUNCE + 1);
    drive_e        raw, prev;
    logic [CW-1:0] cnt, run;
    always_comb begin
        raw = int'(dir) < C - BAND_OUT ? FAST_LEFT :
              int'(dir) < C - BAND_IN  ? LEFT :
              int'(dir) > C + BAND_OUT ? FAST_RIGHT :
              int'(dir) > C + BAND_IN  ? RIGHT : STRAIGHT;
        run = (raw == prev && cnt != '0) ? (cnt == CW'(DEBOUNCE) ? cnt : cnt + 1'b1) : CW'(1);
    end
    // an invalid sample breaks the run but leaves the debounced zone alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            prev <= STRAIGHT;
            zone <= STRAIGHT;
        end else if (!valid) begin
            cnt <= '0;
        end else begin
            cnt  <= run;
            prev <= raw;
            if (run == CW'(DEBOUNCE)) zone <= raw;
        end
    end
endmodule

// File: rtl/drive_controller.sv
// drive_controller: mode FSM, IR handling and steering command handshake for the follower robot
module drive_controller
    import drive_pkg::*;
#(
    parameter int FOV          = 25,
    parameter int DIR_W        = $clog2(FOV) + 1,
    parameter int STUN_TIME    = 600000000,
    parameter int AMP_THRESH   = 50,
    parameter int DIST_DEFAULT = 20,
    parameter int DIST_MIN     = 10,
    parameter int DIST_MAX     = 100,
    parameter int DIST_STEP    = 10,
    parameter int BAND_IN      = 4,
    parameter int BAND_OUT     = 9,
    parameter int DEBOUNCE     = 4,
    parameter int PIX_W        = 17,
    parameter int PIX_T2       = 5000,
    parameter int PIX_T3       = 15000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                no_red,
    input  logic [PIX_W-1:0]    pixel_count,
    input  logic [DIR_W-1:0]    detected_direction,
    input  logic [7:0]          average_distance,
    input  logic [10:0]         amplitude,
    input  logic [31:0]         ir_command,
    input  logic                ir_data_ready,
    drive_controller_if.master  cmd,
    output logic [7:0]          follow_distance,
    output logic [1:0]          multiplier,
    output logic [1:0]          mode
);
    localparam int SW = $clog2(STUN_TIME + 1);
    mode_e         state;
    drive_e        zone, target;
    logic          mute, too_close, loud, power, play, dir_ok;
    logic [SW-1:0] stun_cnt;
    always_comb begin
        power      = ir_data_ready && ir_command == IR_POWER;
        play       = ir_data_ready && ir_command == IR_PLAY;
        loud       = amplitude > 11'(AMP_THRESH) && !mute;
        dir_ok     = !no_red && int'(detected_direction) < FOV;
        target     = (state != TRACK || !dir_ok || too_close) ? STOP : zone;
        multiplier = pixel_count > PIX_W'(PIX_T3) ? 2'd3 : pixel_count > PIX_W'(PIX_T2) ? 2'd2 : 2'd1;
    end
    assign mode = state;
    steer_debounce #(
        .FOV(FOV), .DIR_W(DIR_W), .BAND_IN(BAND_IN), .BAND_OUT(BAND_OUT), .DEBOUNCE(DEBOUNCE)
    ) u_steer (
        .clk(clk), .rst_n(rst_n), .valid(dir_ok), .dir(detected_direction), .zone(zone)
    );
    // continued noise while stunned restarts the stun window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OFF;
            stun_cnt <= '0;
        end else if (power) begin
            state    <= OFF;
            stun_cnt <= '0;
        end else if (state == OFF && play) begin
            state <= TRACK;
        end else if (state == TRACK && loud) begin
            state    <= STUN;
            stun_cnt <= '0;
        end else if (state == STUN) begin
            if (loud) begin
                stun_cnt <= '0;
            end else if (stun_cnt == SW'(STUN_TIME - 1)) begin
                state    <= TRACK;
                stun_cnt <= '0;
            end else begin
                stun_cnt <= stun_cnt + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute            <= 1'b0;
            follow_distance <= 8'(DIST_DEFAULT);
            too_close       <= 1'b1;
        end else begin
            too_close <= average_distance < follow_distance;
            if (ir_data_ready) begin
                if (ir_command == IR_MUTE) mute <= 1'b1;
                if (ir_command == IR_RETURN) begin
                    mute            <= 1'b0;
                    follow_distance <= 8'(DIST_DEFAULT);
                end
                if (ir_command == IR_UP)
                    follow_distance <= int'(follow_distance) + DIST_STEP > DIST_MAX ? 8'(DIST_MAX) : follow_distance + 8'(DIST_STEP);
                if (ir_command == IR_DOWN)
                    follow_distance <= int'(follow_distance) - DIST_STEP < DIST_MIN ? 8'(DIST_MIN) : follow_distance - 8'(DIST_STEP);
            end
        end
    end
    // a Stop target may overwrite a command the motor block has not yet accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd.drive_command <= STOP;
            cmd.cmd_valid     <= 1'b0;
        end else if (target != cmd.drive_command && (!cmd.cmd_valid || cmd.cmd_ready || target == STOP)) begin
            cmd.drive_command <= target;
            cmd.cmd_valid     <= 1'b1;
        end else if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_drive_controller.sv
// tb_drive_controller: directed and randomized checks against a behavioural model of the controller
module tb_drive_controller;
    localparam int FOV = 25, C = 12, STUN_T = 100;
    localparam logic [31:0] PLAY = 32'he9166b86, POWER = 32'hed126b86, MUTE = 32'hf30c6b86;
    localparam logic [31:0] RETN = 32'he8176b86, UP = 32'he51a6b86, DOWN = 32'he11e6b86;
    logic        clk = 0, rst_n = 0, no_red = 0, ir_data_ready = 0;
    logic [16:0] pixel_count = 0;
    logic [5:0]  detected_direction = 12;
    logic [7:0]  average_distance = 200;
    logic [10:0] amplitude = 0;
    logic [31:0] ir_command = 0;
    logic [7:0]  follow_distance;
    logic [1:0]  multiplier, mode;
    int checks = 0, errors = 0;
    bit chk_en = 0;
    drive_controller_if bus();
    drive_controller #(.STUN_TIME(STUN_T)) dut (
        .clk(clk), .rst_n(rst_n), .no_red(no_red), .pixel_count(pixel_count),
        .detected_direction(detected_direction), .average_distance(average_distance),
        .amplitude(amplitude), .ir_command(ir_command), .ir_data_ready(ir_data_ready),
        .cmd(bus.master), .follow_distance(follow_distance), .multiplier(multiplier), .mode(mode)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    // model state: mode 0 OFF / 1 TRACK / 2 STUN, stun tracked as an absolute deadline edge
    int m_mode = 0, m_fd = 20, m_deb = 3, m_cmd = 0, m_edge = 0, m_deadline = 0;
    bit m_mute = 0, m_tc = 1, m_valid = 0;
    int hist[$];
    int d, raw, tgt;
    bit ok, loud, pw, same;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_mute = 0; m_fd = 20; m_tc = 1; m_deb = 3; m_cmd = 0; m_valid = 0;
            hist.delete();
        end else begin
            m_edge++;
            d = int'(detected_direction);
            ok = !no_red && d < FOV;
            raw = !ok ? -1 : d < C - 9 ? 1 : d < C - 4 ? 2 : d > C + 9 ? 5 : d > C + 4 ? 4 : 3;
            tgt = (m_mode != 1 || !ok || m_tc) ? 0 : m_deb;
            loud = amplitude > 50 && !m_mute;
            pw = ir_data_ready && ir_command == POWER;
            if (tgt != m_cmd && (!m_valid || bus.cmd_ready || tgt == 0)) begin
                m_cmd = tgt; m_valid = 1;
            end else if (m_valid && bus.cmd_ready) m_valid = 0;
            m_tc = average_distance < m_fd;
            if (pw) m_mode = 0;
            else if (m_mode == 0 && ir_data_ready && ir_command == PLAY) m_mode = 1;
            else if (m_mode == 1 && loud) begin m_mode = 2; m_deadline = m_edge + STUN_T; end
            else if (m_mode == 2 && loud) m_deadline = m_edge + STUN_T;
            else if (m_mode == 2 && m_edge == m_deadline) m_mode = 1;
            if (ir_data_ready) begin
                if (ir_command == MUTE) m_mute = 1;
                if (ir_command == RETN) begin m_mute = 0; m_fd = 20; end
                if (ir_command == UP) m_fd = m_fd + 10 > 100 ? 100 : m_fd + 10;
                if (ir_command == DOWN) m_fd = m_fd - 10 < 10 ? 10 : m_fd - 10;
            end
            hist.push_back(raw);
            if (hist.size() > 4) void'(hist.pop_front());
            same = hist.size() == 4 && hist[0] > 0;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (same) m_deb = hist[0];
        end
    end
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("drive_command", int'(bus.drive_command), m_cmd);
            chk("cmd_valid", int'(bus.cmd_valid), int'(m_valid));
            chk("mode", int'(mode), m_mode);
            chk("follow_distance", int'(follow_distance), m_fd);
            chk("multiplier", int'(multiplier), pixel_count > 15000 ? 3 : pixel_count > 5000 ? 2 : 1);
        end
    end
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic ir(input logic [31:0] code);
        ir_command = code; ir_data_ready = 1;
        step(1);
        ir_data_ready = 0;
    endtask
    task automatic lit(input string name, input int act, input int exp);
        chk(name, act, exp);
    endtask
    logic [31:0] codes [8] = '{PLAY, PLAY, MUTE, RETN, UP, DOWN, POWER, 32'h12345678};
    initial begin
        bus.cmd_ready = 1;
        step(1); chk_en = 1; step(2);
        rst_n = 1; step(1);
        @(negedge clk);
        lit("rst_cmd", int'(bus.drive_command), 0); lit("rst_valid", int'(bus.cmd_valid), 0);
        lit("rst_mode", int'(mode), 0); lit("rst_fd", int'(follow_distance), 20);
        pixel_count = 5000;  #1 lit("mult_5000", int'(multiplier), 1);
        pixel_count = 5001;  #1 lit("mult_5001", int'(multiplier), 2);
        pixel_count = 15000; #1 lit("mult_15000", int'(multiplier), 2);
        pixel_count = 15001; #1 lit("mult_15001", int'(multiplier), 3);
        ir(PLAY); step(1);
        @(negedge clk); lit("play_cmd", int'(bus.drive_command), 3); lit("play_valid", int'(bus.cmd_valid), 1);
        step(1);
        @(negedge clk); lit("play_valid_drop", int'(bus.cmd_valid), 0);
        detected_direction = 1; step(3); detected_direction = 12; step(4);
        @(negedge clk); lit("deb3_cmd", int'(bus.drive_command), 3);
        detected_direction = 1; step(5);
        @(negedge clk); lit("deb4_cmd", int'(bus.drive_command), 1);
        detected_direction = 12; step(6);
        repeat (10) ir(UP);
        @(negedge clk); lit("fd_up_sat", int'(follow_distance), 100);
        repeat (12) ir(DOWN);
        @(negedge clk); lit("fd_down_sat", int'(follow_distance), 10);
        ir(RETN);
        @(negedge clk); lit("fd_return", int'(follow_distance), 20);
        amplitude = 60; step(1); amplitude = 0; step(1);
        @(negedge clk); lit("stun_mode", int'(mode), 2); lit("stun_cmd", int'(bus.drive_command), 0);
        step(98);
        @(negedge clk); lit("stun_hold", int'(mode), 2);
        step(1);
        @(negedge clk); lit("stun_exit", int'(mode), 1);
        ir(MUTE); amplitude = 60; step(3);
        @(negedge clk); lit("mute_nostun", int'(mode), 1);
        amplitude = 0; ir(RETN); step(3);
        detected_direction = 18; bus.cmd_ready = 0; step(6);
        @(negedge clk); lit("right_cmd", int'(bus.drive_command), 4); lit("right_valid", int'(bus.cmd_valid), 1);
        detected_direction = 7; step(6);
        @(negedge clk); lit("stall_cmd", int'(bus.drive_command), 4);
        no_red = 1; step(1);
        @(negedge clk); lit("preempt_cmd", int'(bus.drive_command), 0); lit("preempt_valid", int'(bus.cmd_valid), 1);
        bus.cmd_ready = 1; step(1);
        @(negedge clk); lit("preempt_ack", int'(bus.cmd_valid), 0);
        no_red = 0; step(6);
        amplitude = 60; ir(POWER); amplitude = 0; step(1);
        @(negedge clk); lit("power_mode", int'(mode), 0); lit("power_cmd", int'(bus.drive_command), 0);
        ir(PLAY); bus.cmd_ready = 0; detected_direction = 12; step(8);
        rst_n = 0; step(2);
        @(negedge clk); lit("midrst_valid", int'(bus.cmd_valid), 0); lit("midrst_cmd", int'(bus.drive_command), 0);
        rst_n = 1; bus.cmd_ready = 1; step(5);
        @(negedge clk); lit("postrst_valid", int'(bus.cmd_valid), 0); lit("postrst_mode", int'(mode), 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) detected_direction = 6'($urandom_range(27));
            no_red = $urandom_range(19) == 0;
            if ($urandom_range(7) == 0) average_distance = 8'($urandom_range(120));
            amplitude = $urandom_range(199) == 0 ? 11'(60) : 11'($urandom_range(52) % 52);
            pixel_count = 17'($urandom_range(20000));
            bus.cmd_ready = $urandom_range(2) != 0;
            ir_data_ready = $urandom_range(29) == 0;
            ir_command = codes[$urandom_range(7)];
            rst_n = $urandom_range(999) != 0;
            step(1);
        end
        rst_n = 1; ir_data_ready = 0; step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/drive_controller.md
DRIVE_CONTROLLER -- requirements
Module: drive_controller

Interface
REQ-001 Parameters (name, default, meaning): FOV 25 steering bins; DIR_W $clog2(FOV)+1 direction width; STUN_TIME 600000000 stun cycles; AMP_THRESH 50 stun amplitude.
REQ-002 Parameters: DIST_DEFAULT 20, DIST_MIN 10, DIST_MAX 100, DIST_STEP 10 follow distance (cm); BAND_IN 4 straight half-width; BAND_OUT 9 fast-turn offset; DEBOUNCE 4 steering-stability cycles.
REQ-003 Parameters: PIX_W 17 pixel-count width; PIX_T2 5000, PIX_T3 15000 multiplier thresholds.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 no_red  in  1  target absent.
REQ-007 pixel_count  in  PIX_W  target pixel count.
REQ-008 detected_direction  in  DIR_W  target bin, 0 = leftmost.
REQ-009 average_distance  in  8  ultrasonic range (cm).
REQ-010 amplitude  in  11  microphone amplitude.
REQ-011 ir_command / ir_data_ready  in  32 / 1  decoded IR word, 1-cycle strobe.
REQ-012 drive_command  out  3  0 Stop, 1 FastLeft, 2 Left, 3 Straight, 4 Right, 5 FastRight.
REQ-013 cmd_valid / cmd_ready  out / in  1 / 1  command handshake to motor block.
REQ-014 follow_distance  out  8; multiplier  out  2; mode  out  2 (0 OFF, 1 TRACK, 2 STUN).

Function
REQ-015 Mode FSM OFF/TRACK/STUN: OFF->TRACK on PLAY (e9166b86); any->OFF on POWER (ed126b86); TRACK->STUN when amplitude > AMP_THRESH and mute clear; STUN->TRACK when stun counter reaches STUN_TIME-1; POWER wins over all same-cycle events.
REQ-016 In STUN, amplitude > AMP_THRESH (mute clear) reloads counter to 0; counter idle (0) outside STUN.
REQ-017 IR decode only on ir_data_ready: MUTE f30c6b86 sets mute; RETURN e8176b86 clears mute and sets follow distance DIST_DEFAULT; UP e51a6b86 adds DIST_STEP saturating at DIST_MAX; DOWN e11e6b86 subtracts DIST_STEP saturating at DIST_MIN; other codes ignored.
REQ-018 too_close registered: average_distance < follow_distance (strict), 1-cycle latency.
REQ-019 Raw zone, centre C = FOV/2: d < C-BAND_OUT FastLeft; d < C-BAND_IN Left; d > C+BAND_OUT FastRight; d > C+BAND_IN Right; else Straight; d >= FOV treated as no_red.
REQ-020 Target command = Stop if mode != TRACK, no_red or too_close; else debounced zone.
REQ-021 Debounced zone changes only after raw zone identical for DEBOUNCE consecutive cycles; Stop bypasses debounce and takes effect next cycle.
REQ-022 Output register loads target when target differs from drive_command and (cmd_valid=0 or cmd_ready=1); cmd_valid rises same edge.
REQ-023 cmd_valid clears on edge where cmd_valid&cmd_ready and no new differing target; drive_command stable while cmd_valid&!cmd_ready.
REQ-024 Stop pre-empts: Stop target overwrites drive_command even while cmd_valid&!cmd_ready, cmd_valid held 1.
REQ-025 multiplier combinational: 3 if pixel_count > PIX_T3, 2 if > PIX_T2, else 1.

Reset
REQ-026 rst_n low: mode OFF, mute 0, follow_distance DIST_DEFAULT, stun counter 0, debounce count 0, debounced zone Straight, too_close 1, drive_command 0, cmd_valid 0.
REQ-027 Reset mid-handshake drops pending command; no cmd_valid until mode TRACK after release.

Structure
REQ-028 Shared package drive_pkg holds drive command enum, mode enum, IR code constants.
REQ-029 Sub-module steer_debounce (zone classify + DEBOUNCE counter) instantiated once.

Verification
REQ-030 Reset, PLAY, direction 12, distance 200, cmd_ready=1 -> drive_command 3, cmd_valid pulse.
REQ-031 Direction 12->1 held 3 cycles then 12 -> no command change; held 4 cycles -> FastLeft (1).
REQ-032 UP strobed 10 times from default -> follow_distance 100; DOWN 12 times -> 10.
REQ-033 amplitude 60 in TRACK -> mode STUN, drive_command 0; STUN_TIME=100 -> TRACK after 100 cycles; mute set -> no stun.
REQ-034 cmd_ready=0 with Right pending, direction to Left -> drive_command stays 4; no_red -> 0 immediately.
REQ-035 POWER and amplitude 60 same cycle -> mode OFF, drive_command 0.
